// File: rtl/comparator_serial.sv
// Bit-serial WIDTH-bit magnitude comparator, MSB-first scan with early exit.
// Supports unsigned and two's-complement operands; results are held until the next decision.
module comparator_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             AgB,
  output logic             AeB,
  output logic             AlB
);

  localparam int unsigned   CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             mode;
  logic [CW-1:0]    cnt;

  logic load;
  logic decide;
  logic dec_gt;
  logic dec_eq;
  logic dec_lt;
  logic x;
  logic y;

  assign x    = a_sh[cnt];
  assign y    = b_sh[cnt];
  assign busy = (state == COMPARE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    decide     = 1'b0;
    dec_gt     = 1'b0;
    dec_eq     = 1'b0;
    dec_lt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (x != y) begin
          decide     = 1'b1;
          state_next = IDLE;
          // In signed mode a differing sign bit means the operand with the 1 is smaller
          if (mode && (cnt == CNT_TOP)) begin
            dec_gt = y;
            dec_lt = x;
          end else begin
            dec_gt = x;
            dec_lt = y;
          end
        end else if (cnt == '0) begin
          decide     = 1'b1;
          dec_eq     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      mode <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
      AgB  <= 1'b0;
      AeB  <= 1'b0;
      AlB  <= 1'b0;
    end else begin
      done <= decide;
      if (load) begin
        a_sh <= a;
        b_sh <= b;
        mode <= signed_mode;
        cnt  <= CNT_TOP;
      end else if ((state == COMPARE) && !decide) begin
        cnt <= cnt - CW'(1);
      end
      if (decide) begin
        AgB <= dec_gt;
        AeB <= dec_eq;
        AlB <= dec_lt;
      end
    end
  end

endmodule
